// File: rtl/snn_layer_pkg.sv
// Shared types and helpers for the time-multiplexed LIF layer.
// SNN_LAYER_SATURATE_EN selects saturating membrane narrowing.
package snn_layer_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic int acc_w(input int nbits, input int n_in);
        return nbits + $clog2(n_in) + 2;
    endfunction

    // Narrow a wide signed sum to nbits; caller keeps the low nbits.
    function automatic logic signed [31:0] narrow_sum(
        input logic signed [31:0] s,
        input int                 nbits
    );
`ifdef SNN_LAYER_SATURATE_EN
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (nbits - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
`else
        return s & ((32'sd1 <<< nbits) - 32'sd1);
`endif
    endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational leak / integrate / threshold / narrow for one neuron.
// Narrowing mode follows SNN_LAYER_SATURATE_EN via snn_layer_pkg.
import snn_layer_pkg::*;

module lif_update_unit #(
    parameter int NBITS = 4,
    parameter int ACC_W = 8
) (
    input  logic [NBITS-1:0]        v,
    input  logic signed [ACC_W-1:0] acc,
    input  logic [NBITS-1:0]        threshold,
    input  logic [NBITS-1:0]        decay,
    output logic                    fire,
    output logic [NBITS-1:0]        v_next
);

    logic signed [ACC_W-1:0] vx;
    logic signed [ACC_W-1:0] dx;
    logic signed [ACC_W-1:0] thx;
    logic signed [ACC_W-1:0] tx;
    logic signed [ACC_W-1:0] leaked;
    logic signed [ACC_W-1:0] sum;
    logic signed [31:0]      nar;

    always_comb begin
        vx     = {{(ACC_W-NBITS){v[NBITS-1]}}, v};
        dx     = {{(ACC_W-NBITS){1'b0}}, decay};
        thx    = {{(ACC_W-NBITS){1'b0}}, threshold};
        tx     = '0;
        leaked = vx;
        // Leak never crosses zero.
        if (vx > 0) begin
            tx     = vx - dx;
            leaked = (tx < 0) ? '0 : tx;
        end else if (vx < 0) begin
            tx     = vx + dx;
            leaked = (tx > 0) ? '0 : tx;
        end
        sum    = leaked + acc;
        fire   = (sum >= thx);
        nar    = narrow_sum(32'(sum), NBITS);
        v_next = nar[NBITS-1:0];
    end

endmodule

// File: rtl/snn_lif_layer_seq.sv
// Time-multiplexed LIF layer: one synapse per clock, valid/ready timestep.
// Define SNN_LAYER_SATURATE_EN for saturating membrane narrowing.
import snn_layer_pkg::*;

module snn_lif_layer_seq #(
    parameter int NBITS = 4,
    parameter int N_IN  = 24,
    parameter int N_OUT = 8
) (
    input  logic                          system_clock,
    input  logic                          reset,
    input  logic                          step_valid,
    output logic                          step_ready,
    input  logic [N_IN-1:0]               input_spikes,
    input  logic [N_IN*N_OUT*NBITS-1:0]   weights,
    input  logic [NBITS-1:0]              threshold,
    input  logic [NBITS-1:0]              decay,
    input  logic [NBITS-1:0]              refractory_period,
    output logic [N_OUT-1:0]              output_spikes,
    output logic                          out_valid,
    output logic [N_OUT*NBITS-1:0]        membrane_potentials
);

    localparam int ACC_W = acc_w(NBITS, N_IN);
    localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    state_t                  state;
    logic [IW-1:0]           i_cnt;
    logic [JW-1:0]           j_cnt;
    logic signed [ACC_W-1:0] acc;
    logic [N_IN-1:0]         spk_lat;
    logic [N_OUT-1:0]        shadow;
    logic [NBITS-1:0]        ref_cnt [N_OUT];

    logic [NBITS-1:0]        w_cur;
    logic signed [ACC_W-1:0] w_ext;
    logic [NBITS-1:0]        v_cur;
    logic                    fire;
    logic [NBITS-1:0]        v_next;

    assign step_ready = (state == S_IDLE);
    assign w_cur = weights[(int'(j_cnt)*N_IN + int'(i_cnt))*NBITS +: NBITS];
    assign w_ext = {{(ACC_W-NBITS){w_cur[NBITS-1]}}, w_cur};
    assign v_cur = membrane_potentials[int'(j_cnt)*NBITS +: NBITS];

    lif_update_unit #(
        .NBITS (NBITS),
        .ACC_W (ACC_W)
    ) u_upd (
        .v         (v_cur),
        .acc       (acc),
        .threshold (threshold),
        .decay     (decay),
        .fire      (fire),
        .v_next    (v_next)
    );

    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            state               <= S_IDLE;
            i_cnt               <= '0;
            j_cnt               <= '0;
            acc                 <= '0;
            spk_lat             <= '0;
            shadow              <= '0;
            output_spikes       <= '0;
            out_valid           <= 1'b0;
            membrane_potentials <= '0;
            for (int k = 0; k < N_OUT; k++) ref_cnt[k] <= '0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (step_valid) begin
                        spk_lat <= input_spikes;
                        i_cnt   <= '0;
                        j_cnt   <= '0;
                        acc     <= '0;
                        state   <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (spk_lat[i_cnt]) acc <= acc + w_ext;
                    if (i_cnt == IW'(N_IN - 1)) begin
                        state <= S_UPDATE;
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                    end
                end
                S_UPDATE: begin
                    // Refractory neurons discard their input this step.
                    if (ref_cnt[j_cnt] != '0) begin
                        ref_cnt[j_cnt] <= ref_cnt[j_cnt] - 1'b1;
                        shadow[j_cnt]  <= 1'b0;
                        membrane_potentials[int'(j_cnt)*NBITS +: NBITS] <= '0;
                    end else if (fire) begin
                        ref_cnt[j_cnt] <= refractory_period;
                        shadow[j_cnt]  <= 1'b1;
                        membrane_potentials[int'(j_cnt)*NBITS +: NBITS] <= '0;
                    end else begin
                        shadow[j_cnt]  <= 1'b0;
                        membrane_potentials[int'(j_cnt)*NBITS +: NBITS] <= v_next;
                    end
                    acc   <= '0;
                    i_cnt <= '0;
                    if (j_cnt == JW'(N_OUT - 1)) begin
                        state <= S_DONE;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                        state <= S_ACCUM;
                    end
                end
                S_DONE: begin
                    output_spikes <= shadow;
                    out_valid     <= 1'b1;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_lif_layer_seq.sv
// Scoreboard bench for snn_lif_layer_seq with a behavioural LIF model.
// Honours SNN_LAYER_SATURATE_EN the same way as the design build.
module tb_snn_lif_layer_seq;

    localparam int NB = 4;
    localparam int NI = 4;
    localparam int NO = 2;
    localparam int L  = NO * (NI + 1) + 1;

    typedef struct {
        int               e0;
        logic [NO-1:0]    spk;
        logic [NO*NB-1:0] pot;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               step_valid = 1'b0;
    logic               step_ready;
    logic [NI-1:0]      in_spk = '0;
    logic [NI*NO*NB-1:0] weights = '0;
    logic [NB-1:0]      threshold = '0;
    logic [NB-1:0]      decay = '0;
    logic [NB-1:0]      refr = '0;
    logic [NO-1:0]      output_spikes;
    logic               out_valid;
    logic [NO*NB-1:0]   pots;

    int   w_m [NO][NI];
    int   v_m [NO];
    int   r_m [NO];
    exp_t q [$];
    exp_t e_mon;
    bit   exp_ov;
    int   cyc = 0;
    int   next_ok = 0;
    int   n_acc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    snn_lif_layer_seq #(
        .NBITS (NB),
        .N_IN  (NI),
        .N_OUT (NO)
    ) dut (
        .system_clock        (clk),
        .reset               (rst_n),
        .step_valid          (step_valid),
        .step_ready          (step_ready),
        .input_spikes        (in_spk),
        .weights             (weights),
        .threshold           (threshold),
        .decay               (decay),
        .refractory_period   (refr),
        .output_spikes       (output_spikes),
        .out_valid           (out_valid),
        .membrane_potentials (pots)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    function automatic int narrow(input int s);
        int t;
`ifdef SNN_LAYER_SATURATE_EN
        t = (s > 7) ? 7 : (s < -8) ? -8 : s;
`else
        t = s & 15;
        if (t > 7) t -= 16;
`endif
        return t;
    endfunction

    task automatic set_w(input int j, input int i, input int w);
        logic [31:0] t;
        w_m[j][i] = w;
        t = w;
        weights[(j*NI+i)*NB +: NB] = t[NB-1:0];
    endtask

    task automatic set_all(input int w);
        for (int j = 0; j < NO; j++)
            for (int i = 0; i < NI; i++) set_w(j, i, w);
    endtask

    task automatic model_step(input logic [NI-1:0] spk);
        exp_t        e;
        int          a, lk, s;
        logic [31:0] tv;
        e.e0  = cyc;
        e.spk = '0;
        e.pot = '0;
        for (int j = 0; j < NO; j++) begin
            a = 0;
            for (int i = 0; i < NI; i++) if (spk[i]) a += w_m[j][i];
            if (r_m[j] > 0) begin
                r_m[j]--;
                v_m[j] = 0;
            end else begin
                lk = v_m[j];
                if (lk > 0) lk = (lk - int'(decay) > 0) ? lk - int'(decay) : 0;
                else if (lk < 0) lk = (lk + int'(decay) < 0) ? lk + int'(decay) : 0;
                s = lk + a;
                if (s >= int'(threshold)) begin
                    e.spk[j] = 1'b1;
                    v_m[j]   = 0;
                    r_m[j]   = int'(refr);
                end else begin
                    v_m[j] = narrow(s);
                end
            end
            tv = v_m[j];
            e.pot[j*NB +: NB] = tv[NB-1:0];
        end
        q.push_back(e);
    endtask

    // Acceptance as the specification defines it, independent of the DUT.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && step_valid && cyc >= next_ok) begin
            model_step(in_spk);
            next_ok = cyc + L + 1;
            n_acc++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("step_ready", 32'(step_ready), 32'(cyc + 1 >= next_ok));
            exp_ov = (q.size() > 0) && (cyc == q[0].e0 + L);
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) begin
                e_mon = q.pop_front();
                chk("output_spikes", 32'(output_spikes), 32'(e_mon.spk));
                chk("potentials", 32'(pots), 32'(e_mon.pot));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        next_ok = 0;
        for (int j = 0; j < NO; j++) begin
            v_m[j] = 0;
            r_m[j] = 0;
        end
        #1;
        chk("rst_step_ready", 32'(step_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_spikes", 32'(output_spikes), 32'd0);
        chk("rst_potentials", 32'(pots), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        @(negedge clk);
        while ((q.size() != 0 || cyc + 1 < next_ok) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [NI-1:0] spk);
        int k;
        k = 0;
        @(negedge clk);
        while (cyc + 1 < next_ok && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("ready_timeout", 32'd0, 32'd1);
        in_spk     = spk;
        step_valid = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
    endtask

    task automatic params(input int w, input int th, input int dc, input int rf);
        set_all(w);
        threshold = NB'(th);
        decay     = NB'(dc);
        refr      = NB'(rf);
    endtask

    initial begin
        int start;
        int k;
        set_all(0);
        repeat (3) @(negedge clk);
        #1;
        chk("init_step_ready", 32'(step_ready), 32'd1);
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_spikes", 32'(output_spikes), 32'd0);
        chk("init_potentials", 32'(pots), 32'd0);
        #1;
        rst_n = 1'b1;

        // Single fire.
        params(2, 5, 0, 0);
        issue(4'b0111);
        wait_done();

        // Integration: 2, 4, 6, then spike.
        do_reset();
        params(1, 7, 0, 0);
        repeat (4) issue(4'b0011);
        wait_done();

        // Positive leak: v=6 then decay 2 -> 4.
        do_reset();
        params(1, 7, 0, 0);
        repeat (3) issue(4'b0011);
        wait_done();
        decay = 4'd2;
        issue(4'b0000);
        wait_done();

        // Negative leak: v=-3 then decay 2 -> -1.
        do_reset();
        params(-1, 7, 0, 0);
        issue(4'b0111);
        wait_done();
        decay = 4'd2;
        issue(4'b0000);
        wait_done();

        // Refractory: spike, silent, silent, spike.
        do_reset();
        params(2, 5, 0, 2);
        repeat (4) issue(4'b1111);
        wait_done();

        // Narrowing of a large negative sum.
        do_reset();
        params(-8, 7, 0, 0);
        issue(4'b1111);
        wait_done();

        // Threshold zero fires on a zero sum.
        do_reset();
        params(-1, 0, 0, 0);
        issue(4'b0000);
        wait_done();

        // Reset during ACCUM aborts the step.
        params(1, 7, 0, 0);
        issue(4'b1111);
        do_reset();
        wait_done();

        // step_valid while busy is ignored.
        params(1, 15, 0, 0);
        issue(4'b1111);
        repeat (2) @(negedge clk);
        in_spk     = 4'b0101;
        step_valid = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
        wait_done();

        // Back-to-back with step_valid held high.
        params(1, 15, 1, 0);
        start      = n_acc;
        in_spk     = 4'b0011;
        step_valid = 1'b1;
        k = 0;
        while (n_acc < start + 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        step_valid = 1'b0;
        if (k >= 200) chk("b2b_timeout", 32'd0, 32'd1);
        wait_done();

        // Randomised steps.
        do_reset();
        for (int n = 0; n < 25; n++) begin
            wait_done();
            for (int j = 0; j < NO; j++)
                for (int i = 0; i < NI; i++)
                    set_w(j, i, int'($urandom_range(15)) - 8);
            threshold = NB'($urandom_range(15));
            decay     = NB'($urandom_range(15));
            refr      = NB'($urandom_range(3));
            issue(NI'($urandom));
            if (n % 4 == 0) issue(NI'($urandom));
        end
        wait_done();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule
